pipe_hazard_unit: RTL and testbench
===================================

// Module: pipe_hazard_unit
// PURPOSE
//  Parametrised hazard/forwarding controller for the in-order RISC-V pipeline, replacing fixed 5-stage stall/forward logic.
//  Tracks rd/RegWrite/MemRead metadata of NSTAGE post-ID stages (stage 1 = EX ... stage NSTAGE = WB) in a shift register.
//  Generates the load-use stall, the IF/ID write enable, the branch flush and the EX operand-forward selects.
//  Adds a global freeze (ext_stall) and saturating stall/bubble counters.
// PARAMETERS
//  NSTAGE    3   post-ID stages tracked (>=2); stage 1 = EX, stage NSTAGE = WB
//  AW        5   register-address width
//  LOAD_FWD  3   first stage index (2..NSTAGE) whose load result is forwardable
//  CW        16  width of the performance counters
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   synchronous, active-high
//  id_valid    in   1   ID holds a real instruction
//  id_rs1      in   AW  ID source 1 address
//  id_rs2      in   AW  ID source 2 address
//  id_rs1_used in   1   ID instruction reads rs1
//  id_rs2_used in   1   ID instruction reads rs2
//  id_rd       in   AW  ID destination address
//  id_regwrite in   1   ID instruction writes rd
//  id_memread  in   1   ID instruction is a load
//  branch_taken in  1   ID resolved a taken branch/jump
//  ext_stall   in   1   freeze the whole pipeline (memory wait)
//  stall       out  1   load-use stall: hold PC and IF/ID, inject bubble into EX
//  if_write    out  1   PC and IF/ID write enable
//  ifid_flush  out  1   load NOP into IF/ID
//  fwd_a       out  $clog2(NSTAGE+1)  EX operand A source: 0 = register file, s = stage s
//  fwd_b       out  $clog2(NSTAGE+1)  EX operand B source, same encoding
//  ex_valid    out  1   stage-1 entry valid
//  stall_cnt   out  CW  saturating count of load-use stall cycles
//  flush_cnt   out  CW  saturating count of ifid_flush cycles
// BEHAVIOUR
//  - Entry per stage: {v, rd, rw, mr, rs1, rs2, u1, u2}. A writer is an entry with v & rw & rd!=0.
//  - Reset (sync): all v=0, counters=0, so stall=0, if_write=1, ifid_flush=0, fwd=0, ex_valid=0. Reset beats ext_stall.
//  - Stall: =1 iff id_valid and a used ID source (rs!=0) matches a load writer in stage s with s+1 < LOAD_FWD.
//    Combinational, same cycle.
//  - if_write = ~stall & ~ext_stall.
//  - ifid_flush = branch_taken & id_valid & ~stall & ~ext_stall. Stall has priority; the branch retries next cycle.
//  - Shift on each edge with ext_stall=0:
//    - stage1 <= (stall | ~id_valid) ? bubble(v=0) : ID fields;
//    - stage s <= stage s-1, for s = 2..NSTAGE.
//  - With ext_stall=1: all entries and counters hold.
//  - Forward for EX operand A (B likewise): stage-1 u1 & rs1!=0 & valid.
//    - Pick the smallest s in 2..NSTAGE with a writer whose rd==rs1, and, if it is a load, s >= LOAD_FWD.
//    - A stage-1 load is never a source. No match -> 0.
//    - The nearest stage wins on multiple matches. x0 is never forwarded.
//  - The register file is write-through: ID reads see the WB write, so the stage-NSTAGE writer causes no stall.
//  - Counters: stall_cnt += 1 on edges with stall & ~ext_stall; flush_cnt += 1 on edges with ifid_flush.
//    Both saturate at 2^CW-1 and do not wrap.
//  - Latency: all outputs are combinational from the current entries and inputs; the metadata advances 1 stage/cycle.
// TESTING
//  - Load-use: lw x5 in EX, ID add x6,x5,x1 -> stall=1, if_write=0 for 1 cycle.
//    Next cycle stall=0 and the bubble sits in EX. When the add reaches EX: fwd_a=3.
//  - Nearest forward: writers of x7 in stage 2 and stage 3, EX reads x7 -> fwd_a=2; EX rs2=x0 matched by rd=0 -> fwd_b=0.
//  - Branch+stall: branch_taken=1 with a load-use hazard -> ifid_flush=0.
//    Next cycle hazard gone -> ifid_flush=1, flush_cnt=1.
//  - ext_stall held 4 cycles mid-stream -> entries, fwd_a/fwd_b, counters unchanged, if_write=0; resume continues exactly.
//  - Reset asserted during a stall with ext_stall=1 -> next edge all v=0, counters 0, stall=0, if_write=1.
//  - NSTAGE=4, LOAD_FWD=4: load in EX -> 2 stall cycles; load in stage 2 -> 1; forward from stage 4 -> fwd=4.
//    CW=2: counters stop at 3.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: parametrised load-use stall, branch flush and EX operand-forward control
module pipe_hazard_unit #(
  parameter int NSTAGE = 3,
  parameter int AW = 5,
  parameter int LOAD_FWD = 3,
  parameter int CW = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          id_valid,
  input  logic [AW-1:0]                 id_rs1,
  input  logic [AW-1:0]                 id_rs2,
  input  logic                          id_rs1_used,
  input  logic                          id_rs2_used,
  input  logic [AW-1:0]                 id_rd,
  input  logic                          id_regwrite,
  input  logic                          id_memread,
  input  logic                          branch_taken,
  input  logic                          ext_stall,
  output logic                          stall,
  output logic                          if_write,
  output logic                          ifid_flush,
  output logic [$clog2(NSTAGE+1)-1:0]   fwd_a,
  output logic [$clog2(NSTAGE+1)-1:0]   fwd_b,
  output logic                          ex_valid,
  output logic [CW-1:0]                 stall_cnt,
  output logic [CW-1:0]                 flush_cnt
);
  localparam int FW = $clog2(NSTAGE+1);
  logic [NSTAGE:1] v, rw, mr, writer;
  logic [AW-1:0] rd [1:NSTAGE];
  logic [AW-1:0] exRs1, exRs2;
  logic exU1, exU2;
  always_comb begin
    writer = '0;
    stall = 1'b0;
    fwd_a = '0;
    fwd_b = '0;
    for (int s = 1; s <= NSTAGE; s++) begin
      writer[s] = v[s] & rw[s] & (rd[s] != '0);
      if (writer[s] && mr[s] && s + 1 < LOAD_FWD && id_valid &&
          ((id_rs1_used && id_rs1 == rd[s]) || (id_rs2_used && id_rs2 == rd[s])))
        stall = 1'b1;
    end
    // descending scan so the nearest eligible writer is the last to assign
    for (int s = NSTAGE; s >= 2; s--) begin
      if (writer[s] && (!mr[s] || s >= LOAD_FWD) && v[1]) begin
        if (exU1 && exRs1 == rd[s]) fwd_a = FW'(s);
        if (exU2 && exRs2 == rd[s]) fwd_b = FW'(s);
      end
    end
  end
  assign if_write = ~stall & ~ext_stall;
  assign ifid_flush = branch_taken & id_valid & ~stall & ~ext_stall;
  assign ex_valid = v[1];
  // only validity and counters need clearing; other fields are gated by v
  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!ext_stall) begin
      v <= {v[NSTAGE-1:1], id_valid & ~stall};
      rw <= {rw[NSTAGE-1:1], id_regwrite};
      mr <= {mr[NSTAGE-1:1], id_memread};
      rd[1] <= id_rd;
      for (int s = 2; s <= NSTAGE; s++) rd[s] <= rd[s-1];
      exRs1 <= id_rs1;
      exRs2 <= id_rs2;
      exU1 <= id_rs1_used;
      exU2 <= id_rs2_used;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (ifid_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: random + directed scoreboard bench for two hazard-unit configurations
module tb_pipe_hazard_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_memread, branch_taken, ext_stall;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic stall0, ifw0, flush0, exv0, stall1, ifw1, flush1, exv1;
  logic [1:0] fa0, fb0;
  logic [2:0] fa1, fb1;
  logic [15:0] sc0, fc0;
  logic [1:0] sc1, fc1;
  pipe_hazard_unit u0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .branch_taken(branch_taken), .ext_stall(ext_stall), .stall(stall0),
    .if_write(ifw0), .ifid_flush(flush0), .fwd_a(fa0), .fwd_b(fb0), .ex_valid(exv0),
    .stall_cnt(sc0), .flush_cnt(fc0));
  pipe_hazard_unit #(.NSTAGE(4), .AW(5), .LOAD_FWD(4), .CW(2)) u1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .branch_taken(branch_taken), .ext_stall(ext_stall), .stall(stall1),
    .if_write(ifw1), .ifid_flush(flush1), .fwd_a(fa1), .fwd_b(fb1), .ex_valid(exv1),
    .stall_cnt(sc1), .flush_cnt(fc1));

  typedef struct packed {logic v, rw, mr; logic [4:0] rd, rs1, rs2; logic u1, u2;} ins_t;
  typedef struct {int stall, ifw, flush, fa, fb, exv, sc, fc;} exp_t;
  ins_t hist [2][1:4];
  int nsT [2] = '{3, 4};
  int lfT [2] = '{3, 4};
  int maxT [2] = '{65535, 3};
  int stallTot [2], flushTot [2];
  exp_t q0 [$], q1 [$];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input int expv);
    checks++;
    if (act !== 32'(expv)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit writes(ins_t e, logic [4:0] r);
    return e.v && e.rw && e.rd != 0 && e.rd == r;
  endfunction

  // ID source r needs a load result that will not yet be forwardable when ID enters EX
  function automatic bit needsWait(int d, logic u, logic [4:0] r);
    for (int s = 1; s <= nsT[d]; s++)
      if (u && r != 0 && writes(hist[d][s], r) && hist[d][s].mr && s + 1 < lfT[d]) return 1;
    return 0;
  endfunction

  function automatic int source(int d, logic u, logic [4:0] r);
    if (!(hist[d][1].v && u && r != 0)) return 0;
    for (int s = 2; s <= nsT[d]; s++)
      if (writes(hist[d][s], r) && (!hist[d][s].mr || s >= lfT[d])) return s;
    return 0;
  endfunction

  function automatic exp_t model(int d);
    exp_t e;
    e.stall = int'(id_valid && (needsWait(d, id_rs1_used, id_rs1) || needsWait(d, id_rs2_used, id_rs2)));
    e.ifw = int'(!e.stall && !ext_stall);
    e.flush = int'(branch_taken && id_valid && !e.stall && !ext_stall);
    e.fa = source(d, hist[d][1].u1, hist[d][1].rs1);
    e.fb = source(d, hist[d][1].u2, hist[d][1].rs2);
    e.exv = int'(hist[d][1].v);
    e.sc = stallTot[d] < maxT[d] ? stallTot[d] : maxT[d];
    e.fc = flushTot[d] < maxT[d] ? flushTot[d] : maxT[d];
    return e;
  endfunction

  task automatic advance(int d, exp_t e);
    if (reset) begin
      for (int s = 1; s <= 4; s++) hist[d][s] = '0;
      stallTot[d] = 0;
      flushTot[d] = 0;
    end else if (!ext_stall) begin
      stallTot[d] += e.stall;
      flushTot[d] += e.flush;
      for (int s = nsT[d]; s >= 2; s--) hist[d][s] = hist[d][s-1];
      hist[d][1] = (e.stall != 0 || !id_valid) ? ins_t'(0) :
        '{v: 1'b1, rw: id_regwrite, mr: id_memread, rd: id_rd, rs1: id_rs1, rs2: id_rs2,
          u1: id_rs1_used, u2: id_rs2_used};
    end
  endtask

  task automatic step(input logic rst, ext, br, idv, input logic [4:0] r1, r2, input logic us1, us2,
                      input logic [4:0] dst, input logic rwr, mrd);
    exp_t e0, e1;
    @(posedge clk);
    #1;
    reset = rst; ext_stall = ext; branch_taken = br; id_valid = idv;
    id_rs1 = r1; id_rs2 = r2; id_rs1_used = us1; id_rs2_used = us2;
    id_rd = dst; id_regwrite = rwr; id_memread = mrd;
    e0 = model(0);
    e1 = model(1);
    q0.push_back(e0);
    q1.push_back(e1);
    advance(0, e0);
    advance(1, e1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("stall0", 32'(stall0), e.stall); chk("if_write0", 32'(ifw0), e.ifw);
        chk("ifid_flush0", 32'(flush0), e.flush); chk("fwd_a0", 32'(fa0), e.fa);
        chk("fwd_b0", 32'(fb0), e.fb); chk("ex_valid0", 32'(exv0), e.exv);
        chk("stall_cnt0", 32'(sc0), e.sc); chk("flush_cnt0", 32'(fc0), e.fc);
      end
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("stall1", 32'(stall1), e.stall); chk("if_write1", 32'(ifw1), e.ifw);
        chk("ifid_flush1", 32'(flush1), e.flush); chk("fwd_a1", 32'(fa1), e.fa);
        chk("fwd_b1", 32'(fb1), e.fb); chk("ex_valid1", 32'(exv1), e.exv);
        chk("stall_cnt1", 32'(sc1), e.sc); chk("flush_cnt1", 32'(fc1), e.fc);
      end
    end
  end

  initial begin : driver
    int extLeft = 0;
    reset = 1; ext_stall = 0; branch_taken = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0;
    id_rs1_used = 0; id_rs2_used = 0; id_rd = 0; id_regwrite = 0; id_memread = 0;
    repeat (2) @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int s = 1; s <= 4; s++) hist[d][s] = '0;
      stallTot[d] = 0;
      flushTot[d] = 0;
    end
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 2, 1, 1, 3, 1, 1);
    // lw x5; add x6,x5,x1 (held while stalled, with a pending branch); then a dependent add
    step(0, 0, 0, 1, 0, 0, 0, 0, 5, 1, 1);
    step(0, 0, 1, 1, 5, 1, 1, 1, 6, 1, 0);
    step(0, 0, 1, 1, 5, 1, 1, 1, 6, 1, 0);
    step(0, 0, 1, 1, 5, 1, 1, 1, 6, 1, 0);
    step(0, 0, 0, 1, 6, 5, 1, 1, 7, 1, 0);
    // two writers of x7 then a reader of x7 and x0
    step(0, 0, 0, 1, 0, 0, 0, 0, 7, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 7, 1, 0);
    step(0, 0, 0, 1, 7, 0, 1, 1, 0, 1, 0);
    step(0, 0, 0, 1, 7, 0, 1, 1, 0, 1, 0);
    repeat (4) step(0, 1, 1, 1, 7, 7, 1, 1, 8, 1, 1);
    step(0, 0, 0, 1, 8, 7, 1, 1, 9, 1, 0);
    // reset lands while a load-use hazard is frozen
    step(0, 0, 0, 1, 0, 0, 0, 0, 5, 1, 1);
    step(1, 1, 0, 1, 5, 0, 1, 0, 6, 1, 0);
    step(0, 0, 0, 1, 5, 0, 1, 0, 6, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      if (extLeft == 0 && $urandom_range(0, 99) < 6) extLeft = $urandom_range(1, 5);
      step($urandom_range(0, 199) == 0, extLeft != 0, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 85, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 45);
      if (extLeft != 0) extLeft--;
    end
    for (int i = 0; i < 10 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(q0.size() + q1.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
